// File: rtl/robot_world_sim.sv
// Grid-world plant for the wall-following controller: consumes a/r motion commands, produces h/l sensors.
// Motions take MOVE_CYCLES edges after the sampling edge; commands arriving while busy are dropped, not queued.
`timescale 1ns/1ps
module robot_world_sim #(
  parameter int                   GRID        = 8,
  parameter logic [GRID*GRID-1:0] WALLS       = '0,
  parameter int                   START_X     = 0,
  parameter int                   START_Y     = 0,
  parameter int                   START_DIR   = 0,
  parameter int                   MOVE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a,
  input  logic        r,
  input  logic        clear_flags,
  output logic        h,
  output logic        l,
  output logic        busy,
  output logic [3:0]  pos_x,
  output logic [3:0]  pos_y,
  output logic [1:0]  dir,
  output logic [15:0] steps,
  output logic        collision,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, MOVE, ROTATE} state_t;

  localparam int            CW       = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MOVE_CYCLES - 1);
  localparam logic [3:0]    RST_X    = 4'(START_X);
  localparam logic [3:0]    RST_Y    = 4'(START_Y);
  localparam logic [1:0]    RST_DIR  = 2'(START_DIR);

  function automatic logic signed [5:0] delta_x(input logic [1:0] d);
    case (d)
      2'd1:    return 6'sd1;
      2'd3:    return -6'sd1;
      default: return 6'sd0;
    endcase
  endfunction

  function automatic logic signed [5:0] delta_y(input logic [1:0] d);
    case (d)
      2'd0:    return 6'sd1;
      2'd2:    return -6'sd1;
      default: return 6'sd0;
    endcase
  endfunction

  // Anything off the map counts as a wall, so the robot can never leave the grid.
  function automatic logic is_blocked(input logic signed [5:0] x, input logic signed [5:0] y);
    logic [GRID*GRID-1:0] shifted;
    int                   idx;
    if (x < 0 || y < 0 || int'(x) >= GRID || int'(y) >= GRID) return 1'b1;
    idx     = int'(y) * GRID + int'(x);
    shifted = WALLS >> idx;
    return shifted[0];
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        pos_x_d, pos_y_d;
  logic [1:0]        dir_d, left_dir;
  logic [15:0]       steps_d;
  logic              collision_d, illegal_d;
  logic signed [5:0] px, py, ahead_x, ahead_y, left_x, left_y;

  assign px       = $signed({2'b00, pos_x});
  assign py       = $signed({2'b00, pos_y});
  assign left_dir = dir + 2'd3;
  assign ahead_x  = px + delta_x(dir);
  assign ahead_y  = py + delta_y(dir);
  assign left_x   = px + delta_x(left_dir);
  assign left_y   = py + delta_y(left_dir);
  assign h        = is_blocked(ahead_x, ahead_y);
  assign l        = is_blocked(left_x, left_y);
  assign busy     = (state_q != IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pos_x_d     = pos_x;
    pos_y_d     = pos_y;
    dir_d       = dir;
    steps_d     = steps;
    collision_d = collision & ~clear_flags;
    illegal_d   = illegal & ~clear_flags;
    case (state_q)
      IDLE: begin
        if (a && r) begin
          illegal_d = 1'b1;
        end else if (a) begin
          if (h) begin
            collision_d = 1'b1;
          end else begin
            state_d = MOVE;
            cnt_d   = CNT_LOAD;
          end
        end else if (r) begin
          state_d = ROTATE;
          cnt_d   = CNT_LOAD;
        end
      end
      MOVE, ROTATE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // ahead_* is still in range here because the move was only accepted with h=0.
          if (state_q == MOVE) begin
            pos_x_d = ahead_x[3:0];
            pos_y_d = ahead_y[3:0];
          end else begin
            dir_d = dir + 2'd1;
          end
          if (steps != 16'hFFFF) steps_d = steps + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pos_x     <= RST_X;
      pos_y     <= RST_Y;
      dir       <= RST_DIR;
      steps     <= '0;
      collision <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pos_x     <= pos_x_d;
      pos_y     <= pos_y_d;
      dir       <= dir_d;
      steps     <= steps_d;
      collision <= collision_d;
      illegal   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_robot_world_sim.sv
// Scoreboard bench for robot_world_sim: directed scenarios then random commands against a pose/timeline model.
`timescale 1ns/1ps
module tb_robot_world_sim;

  localparam int          G  = 4;
  localparam int          MC = 4;
  localparam logic [15:0] W  = 16'h0402;  // cells (1,0) and (2,2) blocked

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a = 1'b0, r = 1'b0, clear_flags = 1'b0;
  logic        h, l, busy, collision, illegal;
  logic [3:0]  pos_x, pos_y;
  logic [1:0]  dir;
  logic [15:0] steps;

  always #5 clk = ~clk;

  robot_world_sim #(
    .GRID(G), .WALLS(W), .START_X(0), .START_Y(0), .START_DIR(0), .MOVE_CYCLES(MC)
  ) dut (
    .clk(clk), .reset(reset), .a(a), .r(r), .clear_flags(clear_flags),
    .h(h), .l(l), .busy(busy), .pos_x(pos_x), .pos_y(pos_y), .dir(dir),
    .steps(steps), .collision(collision), .illegal(illegal)
  );

  typedef struct packed {
    logic [3:0]  x;
    logic [3:0]  y;
    logic [1:0]  d;
    logic        h;
    logic        l;
    logic        busy;
    logic [15:0] steps;
    logic        coll;
    logic        ill;
  } snap_t;

  snap_t exp_q[$];
  snap_t mon_e, mon_g;
  int    checks = 0;
  int    errors = 0;

  // Reference model: pose plus the edge number on which the current motion completes.
  int mx, my, md, msteps, edge_no, finish_edge;
  bit mcoll, mill, mbusy, mmove;

  function automatic bit blocked(int x, int y);
    if (x < 0 || y < 0 || x >= G || y >= G) return 1'b1;
    return W[y*G + x];
  endfunction

  function automatic int ddx(int d);
    return (d == 1) ? 1 : ((d == 3) ? -1 : 0);
  endfunction

  function automatic int ddy(int d);
    return (d == 0) ? 1 : ((d == 2) ? -1 : 0);
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    int    ld;
    ld      = (md + 3) % 4;
    s.x     = 4'(mx);
    s.y     = 4'(my);
    s.d     = 2'(md);
    s.h     = blocked(mx + ddx(md), my + ddy(md));
    s.l     = blocked(mx + ddx(ld), my + ddy(ld));
    s.busy  = mbusy;
    s.steps = 16'(msteps);
    s.coll  = mcoll;
    s.ill   = mill;
    return s;
  endfunction

  task automatic model_reset();
    mx = 0; my = 0; md = 0; msteps = 0;
    mcoll = 0; mill = 0; mbusy = 0; mmove = 0;
  endtask

  task automatic model_edge(bit ia, bit ir, bit ic);
    edge_no++;
    if (ic) begin
      mcoll = 0;
      mill  = 0;
    end
    if (mbusy) begin
      if (edge_no == finish_edge) begin
        if (mmove) begin
          mx = mx + ddx(md);
          my = my + ddy(md);
        end else begin
          md = (md + 1) % 4;
        end
        if (msteps < 65535) msteps++;
        mbusy = 0;
      end
    end else if (ia && ir) begin
      mill = 1;
    end else if (ia) begin
      if (blocked(mx + ddx(md), my + ddy(md))) mcoll = 1;
      else begin
        mbusy = 1; mmove = 1; finish_edge = edge_no + MC;
      end
    end else if (ir) begin
      mbusy = 1; mmove = 0; finish_edge = edge_no + MC;
    end
  endtask

  task automatic cyc(bit ia, bit ir, bit ic);
    a = ia; r = ir; clear_flags = ic;
    model_edge(ia, ir, ic);
    exp_q.push_back(model_snap());
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; a = 1'b0; r = 1'b0; clear_flags = 1'b0;
    model_reset();
    exp_q.push_back(model_snap());
    @(posedge clk);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e       = exp_q.pop_front();
      mon_g.x     = pos_x;
      mon_g.y     = pos_y;
      mon_g.d     = dir;
      mon_g.h     = h;
      mon_g.l     = l;
      mon_g.busy  = busy;
      mon_g.steps = steps;
      mon_g.coll  = collision;
      mon_g.ill   = illegal;
      checks++;
      if (mon_g !== mon_e) begin
        errors++;
        $display("FAIL state_chk @%0t: got x=%0d y=%0d dir=%0d h=%b l=%b busy=%b steps=%0d coll=%b ill=%b; expected x=%0d y=%0d dir=%0d h=%b l=%b busy=%b steps=%0d coll=%b ill=%b",
                 $time, mon_g.x, mon_g.y, mon_g.d, mon_g.h, mon_g.l, mon_g.busy, mon_g.steps, mon_g.coll, mon_g.ill,
                 mon_e.x, mon_e.y, mon_e.d, mon_e.h, mon_e.l, mon_e.busy, mon_e.steps, mon_e.coll, mon_e.ill);
      end
    end
  end

  initial begin
    edge_no = 0;
    finish_edge = 0;
    model_reset();
    @(negedge clk);
    #1;
    do_reset();

    // Held advance up column 0, then bump into the top edge.
    repeat (17) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    idle(1);

    // Face east into the wall at (1,0), collide, clear.
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    idle(4);
    cyc(1'b1, 1'b0, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1);

    // Four rotations, then a second r while busy must be ignored.
    do_reset();
    repeat (4) begin
      cyc(1'b0, 1'b1, 1'b0);
      idle(4);
    end
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    idle(4);

    // Illegal flag, set-wins-over-clear, then clear.
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    idle(1);

    // Reset in the middle of a move aborts it.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    idle(2);
    do_reset();
    idle(5);

    // Random commands with occasional clears and resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 2) do_reset();
      else cyc($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 5);
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
